// File: rtl/core_mem_pkg.sv
// Shared constants and types for the core memory responder: I/O page layout,
// default I/O base and the address-region decode.
package core_mem_pkg;

    localparam logic [14:0] CORE_MEM_IO_BASE = 15'h7F00;

    localparam logic [7:0] IO_LED    = 8'h00;
    localparam logic [7:0] IO_SW     = 8'h01;
    localparam logic [7:0] IO_TMR_LO = 8'h02;
    localparam logic [7:0] IO_TMR_HI = 8'h03;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        REGION_RAM      = 2'd0,
        REGION_IO       = 2'd1,
        REGION_UNMAPPED = 2'd2
    } region_t;

    // RAM wins if the two windows ever overlap, so a full-width RAM shadows the page.
    function automatic region_t decode_region(input logic [14:0] a,
                                              input int          ram_aw,
                                              input logic [6:0]  io_page);
        region_t r;
        if ((32'(a) >> ram_aw) == 32'd0) begin
            r = REGION_RAM;
        end else if (a[14:8] == io_page) begin
            r = REGION_IO;
        end else begin
            r = REGION_UNMAPPED;
        end
        return r;
    endfunction

endpackage

// File: rtl/core_mem_bram.sv
// Single-port read-first synchronous RAM, written in the shape block RAM
// inference expects. Contents are deliberately not reset.
module core_mem_bram #(
    parameter int AW = 14,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Read and write share the edge; the read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder: block RAM plus a small I/O page (LED, synced switches,
// cycle timer). The timer is only built when CORE_MEM_TIMER_EN is defined.
module core_mem_responder
    import core_mem_pkg::*;
#(
    parameter int          RAM_AW  = 14,
    parameter logic [14:0] IO_BASE = CORE_MEM_IO_BASE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [14:0] addr,
    input  logic        W,
    input  logic [15:0] inData,
    output logic [15:0] outData,
    input  logic [15:0] sw,
    output logic [15:0] led
);

    region_t     region_cur;
    region_t     region_reg;
    logic [7:0]  io_off;
    logic        io_sel;
    logic        io_wr;
    logic        ram_we;
    logic [15:0] ram_rdata;

    logic [15:0] led_reg, led_next;
    logic [15:0] io_rd_reg, io_rd_next;
    logic [SYNC_STAGES-1:0][15:0] sync_reg, sync_next;

    assign region_cur = decode_region(addr, RAM_AW, IO_BASE[14:8]);
    assign io_off     = addr[7:0];
    assign io_sel     = (region_cur == REGION_IO);
    assign io_wr      = io_sel && W;
    assign ram_we     = W && (region_cur == REGION_RAM);

    core_mem_bram #(
        .AW (RAM_AW),
        .DW (16)
    ) u_bram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr[RAM_AW-1:0]),
        .wdata (inData),
        .rdata (ram_rdata)
    );

    // Switch synchronizer chain: stage 0 samples the asynchronous pins.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = sw;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

`ifdef CORE_MEM_TIMER_EN
    logic [31:0] cnt_reg, cnt_next;
    logic [15:0] hi_snap_reg, hi_snap_next;

    // A clear beats the increment; a plain LO read freezes the matching high half.
    always_comb begin
        cnt_next     = cnt_reg + 32'd1;
        hi_snap_next = hi_snap_reg;
        if (io_sel && (io_off == IO_TMR_LO)) begin
            if (W) begin
                cnt_next = 32'd0;
            end else begin
                hi_snap_next = cnt_reg[31:16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= 32'd0;
            hi_snap_reg <= 16'd0;
        end else begin
            cnt_reg     <= cnt_next;
            hi_snap_reg <= hi_snap_next;
        end
    end
`endif

    always_comb begin
        led_next = led_reg;
        if (io_wr && (io_off == IO_LED)) begin
            led_next = inData;
        end
    end

    always_comb begin
        io_rd_next = 16'd0;
        if (io_sel) begin
            case (io_off)
                IO_LED:    io_rd_next = led_reg;
                IO_SW:     io_rd_next = sync_reg[SYNC_STAGES-1];
`ifdef CORE_MEM_TIMER_EN
                IO_TMR_LO: io_rd_next = cnt_reg[15:0];
                IO_TMR_HI: io_rd_next = hi_snap_reg;
`endif
                default:   io_rd_next = 16'd0;
            endcase
        end
    end

    // Region is remembered so the returned word matches last cycle's address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            region_reg <= REGION_UNMAPPED;
            io_rd_reg  <= 16'd0;
            led_reg    <= 16'd0;
            sync_reg   <= '0;
        end else begin
            region_reg <= region_cur;
            io_rd_reg  <= io_rd_next;
            led_reg    <= led_next;
            sync_reg   <= sync_next;
        end
    end

    always_comb begin
        case (region_reg)
            REGION_RAM: outData = ram_rdata;
            REGION_IO:  outData = io_rd_reg;
            default:    outData = 16'd0;
        endcase
    end

    assign led = led_reg;

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed self-checking bench for core_mem_responder; expectations follow the
// CORE_MEM_TIMER_EN setting of the build.
module tb_core_mem_responder;

    logic        clk;
    logic        rst_n;
    logic [14:0] addr;
    logic        W;
    logic [15:0] inData;
    logic [15:0] outData;
    logic [15:0] sw;
    logic [15:0] led;

    int checks   = 0;
    int failures = 0;

    core_mem_responder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .W       (W),
        .inData  (inData),
        .outData (outData),
        .sw      (sw),
        .led     (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive, take the edge, sample 1 time unit later.
    task automatic step(input logic [14:0] a, input logic w, input logic [15:0] d);
        addr   = a;
        W      = w;
        inData = d;
        @(posedge clk);
        #1;
        $display("txn addr=%h W=%b inData=%h -> outData=%h led=%h", a, w, d, outData, led);
    endtask

    initial begin
        rst_n  = 1'b0;
        addr   = 15'h5000;
        W      = 1'b0;
        inData = 16'h0000;
        sw     = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outData", outData, 16'h0000);
        check("reset_led", led, 16'h0000);
        rst_n = 1'b1;

        // RAM write then read-back
        step(15'h0005, 1'b1, 16'hBEEF);
        step(15'h0005, 1'b0, 16'h0000);
        check("ram_wr_rd", outData, 16'hBEEF);

        // read-first during write
        step(15'h0007, 1'b1, 16'h00AA);
        step(15'h0007, 1'b1, 16'h1234);
        check("ram_rdw_old", outData, 16'h00AA);
        step(15'h0007, 1'b0, 16'h0000);
        check("ram_rdw_new", outData, 16'h1234);

        // top RAM word, and first address past RAM must not alias word 0
        step(15'h3FFF, 1'b1, 16'h5A5A);
        step(15'h3FFF, 1'b0, 16'h0000);
        check("ram_top_word", outData, 16'h5A5A);
        step(15'h0000, 1'b1, 16'h1111);
        step(15'h4000, 1'b1, 16'h2222);
        check("unmapped_4000_rd", outData, 16'h0000);
        step(15'h0000, 1'b0, 16'h0000);
        check("ram_no_alias", outData, 16'h1111);

        // LED register
        step(15'h7F00, 1'b1, 16'h00F0);
        check("led_after_wr", led, 16'h00F0);
        check("led_wr_cycle_rd_old", outData, 16'h0000);
        step(15'h7F00, 1'b0, 16'h0000);
        check("led_rd", outData, 16'h00F0);
        step(15'h7F01, 1'b1, 16'hFFFF);
        check("sw_wr_ignored_rd", outData, 16'h0000);
        check("sw_wr_led_kept", led, 16'h00F0);

        // switch synchronizer: two flops plus read latency
        sw = 16'hA5A5;
        step(15'h7F01, 1'b0, 16'h0000);
        step(15'h7F01, 1'b0, 16'h0000);
        check("sw_sync_2cyc", outData, 16'h0000);
        step(15'h7F01, 1'b0, 16'h0000);
        check("sw_sync_3cyc", outData, 16'hA5A5);

        // unmapped accesses
        step(15'h5000, 1'b0, 16'h0000);
        check("unmapped_rd", outData, 16'h0000);
        step(15'h5000, 1'b1, 16'hFFFF);
        check("unmapped_wr_led", led, 16'h00F0);
        step(15'h0005, 1'b0, 16'h0000);
        check("unmapped_wr_ram", outData, 16'hBEEF);
        step(15'h7F04, 1'b1, 16'h1234);
        step(15'h7F04, 1'b0, 16'h0000);
        check("io_reserved_rd", outData, 16'h0000);
        check("io_reserved_led", led, 16'h00F0);

        // timer: clear then 0, 1
        step(15'h7F02, 1'b1, 16'h0000);
        step(15'h7F02, 1'b0, 16'h0000);
        check("tmr_after_clr0", outData, 16'h0000);
        step(15'h7F02, 1'b0, 16'h0000);
`ifdef CORE_MEM_TIMER_EN
        check("tmr_after_clr1", outData, 16'h0001);
`else
        check("tmr_after_clr1", outData, 16'h0000);
`endif

        // timer: 70000 idle cycles after a clear -> count 0x00011170
        step(15'h7F02, 1'b1, 16'h0000);
        addr = 15'h5000;
        W    = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        step(15'h7F02, 1'b0, 16'h0000);
`ifdef CORE_MEM_TIMER_EN
        check("tmr_lo_70000", outData, 16'h1170);
`else
        check("tmr_lo_70000", outData, 16'h0000);
`endif
        step(15'h7F03, 1'b0, 16'h0000);
`ifdef CORE_MEM_TIMER_EN
        check("tmr_hi_70000", outData, 16'h0001);
`else
        check("tmr_hi_70000", outData, 16'h0000);
`endif

        // asynchronous reset mid-cycle
        step(15'h7F00, 1'b0, 16'h0000);
        check("pre_rst_led_rd", outData, 16'h00F0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_led", led, 16'h0000);
        check("async_rst_outData", outData, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(15'h7F03, 1'b0, 16'h0000);
        check("post_rst_hi_snap", outData, 16'h0000);
        check("post_rst_led", led, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
